// File: rtl/m_axi_burst_fifo_if.sv
// Handshake bundle between the m_axi burst FIFO and its producer/consumer.
// The FIFO takes the slave side; the burst issue logic or kernel stream takes the master side.
interface m_axi_burst_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_space_avail;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic                  if_burst_avail;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic [1:0]            if_err;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_space_avail, if_dout, if_empty_n,
        input  if_burst_avail, if_num_data_valid, if_err
    );

    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_space_avail, if_dout, if_empty_n,
        output if_burst_avail, if_num_data_valid, if_err
    );
endinterface

// File: rtl/m_axi_burst_fifo.sv
// First-word-fall-through FIFO with burst-granular space/data flags, synchronous flush
// and sticky write-while-full / read-while-empty error bits.
module m_axi_burst_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BURST_LEN  = 16,
    parameter     MEM_STYLE  = "block"
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               flush,
    m_axi_burst_fifo_if.slave  fifo_if
);
    localparam int                    CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0]         C_BURST = CW'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 2);

    if (DEPTH < 2 || (2 ** ADDR_WIDTH) < DEPTH || BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_geometry
        $error("m_axi_burst_fifo: illegal DEPTH/ADDR_WIDTH/BURST_LEN combination");
    end
    if (MEM_STYLE != "block" && MEM_STYLE != "distributed" && MEM_STYLE != "shiftreg") begin : g_bad_style
        $error("m_axi_burst_fifo: unknown MEM_STYLE");
    end

    // Storage holds DEPTH-1 words; the output register is the last slot of capacity.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-2];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]         r_mem_cnt;
    logic                  r_dout_vld;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [1:0]            r_err;

    logic                  w_clr;
    logic                  w_full_n;
    logic                  w_push;
    logic                  w_take;
    logic                  w_pop;
    logic [CW-1:0]         w_total;
    logic [CW-1:0]         w_num;

    assign w_clr    = reset | flush;
    assign w_total  = r_mem_cnt + CW'(r_dout_vld);
    assign w_full_n = (w_total < C_DEPTH);
    assign w_push   = clk_en & ~w_clr & fifo_if.if_write & w_full_n;
    assign w_take   = clk_en & ~w_clr & fifo_if.if_read & r_dout_vld;
    assign w_pop    = clk_en & ~w_clr & (r_mem_cnt != '0) & (~r_dout_vld | w_take);
    assign w_num    = r_dout_vld ? (r_mem_cnt + CW'(1)) : '0;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_mem_cnt  <= '0;
            r_dout_vld <= 1'b0;
            r_err      <= 2'b00;
        end else if (clk_en) begin
            if (w_push) begin
                r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
            end
            r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_pop);
            if (w_pop) begin
                r_dout_vld <= 1'b1;
            end else if (w_take) begin
                r_dout_vld <= 1'b0;
            end
            if (fifo_if.if_write & ~w_full_n) begin
                r_err[0] <= 1'b1;
            end
            if (fifo_if.if_read & ~r_dout_vld) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    // With storage full and the output register empty, a push and pop share one address;
    // the read below sees the old (oldest) word, which is what must go out first.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= fifo_if.if_din;
        end
        if (w_pop) begin
            r_dout <= r_mem[r_rptr];
        end
    end

    assign fifo_if.if_full_n         = w_full_n;
    assign fifo_if.if_empty_n        = r_dout_vld;
    assign fifo_if.if_dout           = r_dout;
    assign fifo_if.if_num_data_valid = w_num;
    assign fifo_if.if_burst_avail    = (w_num >= C_BURST);
    assign fifo_if.if_space_avail    = ((C_DEPTH - w_total) >= C_BURST);
    assign fifo_if.if_err            = r_err;
endmodule

// File: tb/tb_m_axi_burst_fifo.sv
// Directed bench for m_axi_burst_fifo: stimulus queues expected words, a negedge monitor
// compares every word the FIFO hands out, and flag checks use hand-computed values.
module tb_m_axi_burst_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int BL    = 16;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    logic flush;

    m_axi_burst_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    m_axi_burst_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BURST_LEN(BL), .MEM_STYLE("block")
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .fifo_if(bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [DW-1:0] exp_q [$];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    // Scoreboard monitor: a word leaves the FIFO on any enabled read while if_empty_n is high.
    always @(negedge clk) begin
        if (!reset && !flush && clk_en && bus.if_read && bus.if_empty_n) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got 0x%0h, want no word", bus.if_dout);
            end else begin
                chk("sb_data", bus.if_dout, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input bit en, input bit wr, input logic [DW-1:0] d, input bit acc,
                       input bit rd, input bit fl);
        clk_en       = en;
        bus.if_write = wr;
        bus.if_din   = d;
        bus.if_read  = rd;
        flush        = fl;
        if (fl) exp_q.delete();
        else if (en && wr && acc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        clk_en       = 1'b1;
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd1();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wr1(input logic [DW-1:0] d);
        cyc(1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_n;
        int rd_n;
        int max_num;
        int cycles;
        bit en;
        bit wr;
        bit rd;
        logic [DW-1:0] d;

        clk_en       = 1'b1;
        flush        = 1'b0;
        bus.if_write = 1'b0;
        bus.if_din   = '0;
        bus.if_read  = 1'b0;
        do_reset();

        chk("rst_full_n", bus.if_full_n, 1);
        chk("rst_empty_n", bus.if_empty_n, 0);
        chk("rst_space", bus.if_space_avail, 1);
        chk("rst_burst", bus.if_burst_avail, 0);
        chk("rst_num", bus.if_num_data_valid, 0);
        chk("rst_err", bus.if_err, 0);

        // Five words, two-cycle first-word latency, then drain in order.
        wr1(32'h1);
        chk("t1_empty_n_c1", bus.if_empty_n, 0);
        wr1(32'h2);
        chk("t1_empty_n_c2", bus.if_empty_n, 1);
        chk("t1_head", bus.if_dout, 32'h1);
        for (int k = 3; k <= 5; k++) wr1(DW'(k));
        chk("t1_num5", bus.if_num_data_valid, 5);
        for (int k = 0; k < 5; k++) rd1();
        chk("t1_empty_after", bus.if_empty_n, 0);
        chk("t1_num_after", bus.if_num_data_valid, 0);

        // Fill to DEPTH, overflow write, one read reopens space.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            wr1(32'h100 + DW'(i));
            if (i == 16) chk("t2_space_at16", bus.if_space_avail, 1);
            if (i == 17) chk("t2_space_at17", bus.if_space_avail, 0);
            if (i == 31) chk("t2_full_n_at31", bus.if_full_n, 1);
        end
        chk("t2_full_n_at32", bus.if_full_n, 0);
        cyc(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        chk("t2_err_ovf", bus.if_err, 1);
        chk("t2_num_full", bus.if_num_data_valid, 32);
        rd1();
        chk("t2_full_n_after_rd", bus.if_full_n, 1);
        for (int i = 0; i < DEPTH - 1; i++) rd1();
        chk("t2_empty_drained", bus.if_empty_n, 0);
        chk("t2_err_sticky", bus.if_err, 1);

        // Flush with a concurrent write while holding 10 words and a set error bit.
        for (int i = 1; i <= 10; i++) wr1(32'h200 + DW'(i));
        idle(2);
        chk("t5_num10", bus.if_num_data_valid, 10);
        cyc(1'b1, 1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1);
        chk("t5_empty_n", bus.if_empty_n, 0);
        chk("t5_num", bus.if_num_data_valid, 0);
        chk("t5_full_n", bus.if_full_n, 1);
        chk("t5_err", bus.if_err, 0);
        idle(3);
        chk("t5_write_dropped", bus.if_empty_n, 0);

        // Burst flag threshold, clock-enable freeze, then a back-to-back burst read.
        do_reset();
        for (int i = 1; i <= 15; i++) wr1(32'h300 + DW'(i));
        idle(2);
        chk("t3_num15", bus.if_num_data_valid, 15);
        chk("t3_burst15", bus.if_burst_avail, 0);
        wr1(32'h310);
        idle(2);
        chk("t3_num16", bus.if_num_data_valid, 16);
        chk("t3_burst16", bus.if_burst_avail, 1);
        repeat (3) cyc(1'b0, 1'b1, 32'hBAD, 1'b1, 1'b1, 1'b0);
        chk("t3_freeze_num", bus.if_num_data_valid, 16);
        chk("t3_freeze_dout", bus.if_dout, 32'h301);
        chk("t3_freeze_err", bus.if_err, 0);
        for (int i = 0; i < BL; i++) begin
            chk("t3_burst_rd_empty_n", bus.if_empty_n, 1);
            rd1();
        end
        chk("t3_empty_after", bus.if_empty_n, 0);

        // Read while empty: gated read sets nothing, enabled read sets bit 1 until reset.
        do_reset();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t6_gated_rd_err", bus.if_err, 0);
        rd1();
        chk("t6_err_udf", bus.if_err, 2);
        for (int i = 1; i <= 3; i++) wr1(32'h400 + DW'(i));
        idle(2);
        for (int i = 0; i < 3; i++) rd1();
        chk("t6_err_sticky", bus.if_err, 2);
        do_reset();
        chk("t6_err_cleared", bus.if_err, 0);

        // 1000-word stream with random clock enable.
        wr_n    = 0;
        rd_n    = 0;
        max_num = 0;
        cycles  = 0;
        while (rd_n < 1000 && cycles < 6000) begin
            en = ($urandom_range(0, 3) != 0);
            wr = (wr_n < 1000);
            rd = bus.if_empty_n;
            d  = $urandom;
            if (int'(bus.if_num_data_valid) > max_num) max_num = int'(bus.if_num_data_valid);
            if (en && wr) wr_n++;
            if (en && rd) rd_n++;
            cyc(en, wr, d, 1'b1, rd, 1'b0);
            cycles++;
        end
        chk("t4_words_read", rd_n, 1000);
        chk("t4_max_le_depth", (max_num <= DEPTH), 1);
        chk("t4_err", bus.if_err, 0);
        chk("t4_queue_empty", exp_q.size(), 0);
        idle(2);
        chk("t4_empty_end", bus.if_empty_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
